// File: rtl/read_ptr_ctrl_if.sv
// Read-side FIFO pointer bus: requests and write-pointer feed in, status and pointers out.
interface read_ptr_ctrl_if #(
  parameter int ptr_size = 4
);
  logic                rd_en;
  logic [ptr_size:0]   g_wr_ptr_sync;
  logic [ptr_size:0]   ae_level;
  logic                clr_err;
  logic                empty;
  logic                almost_empty;
  logic [ptr_size:0]   rd_count;
  logic                rd_valid;
  logic                underflow;
  logic [ptr_size:0]   b_rd_ptr;
  logic [ptr_size-1:0] rd_addr;
  logic [ptr_size:0]   g_rd_ptr;

  modport master (
    output rd_en, g_wr_ptr_sync, ae_level, clr_err,
    input  empty, almost_empty, rd_count, rd_valid, underflow, b_rd_ptr, rd_addr, g_rd_ptr
  );
  modport slave (
    input  rd_en, g_wr_ptr_sync, ae_level, clr_err,
    output empty, almost_empty, rd_count, rd_valid, underflow, b_rd_ptr, rd_addr, g_rd_ptr
  );
endinterface

// File: rtl/read_ptr_ctrl.sv
// Async FIFO read-domain pointer/status controller: Gray/binary read pointers,
// registered occupancy, almost-empty, latency-aligned read-valid and sticky underflow.
module read_ptr_ctrl #(
  parameter int ptr_size   = 4,
  parameter int rd_latency = 1
) (
  input  logic           rd_clk,
  input  logic           rst,
  read_ptr_ctrl_if.slave bus
);
  localparam int W = ptr_size + 1;

  logic [W-1:0]          b_q, b_d, g_q, g_d, cnt_q, cnt_d, b_wr;
  logic                  empty_q, empty_d, ae_q, ae_d, uf_q, uf_d;
  logic                  rd_acc;
  logic [rd_latency-1:0] vld_q;
  logic [rd_latency:0]   vld_pipe;

  always_comb begin
    rd_acc = bus.rd_en & ~empty_q;
    b_d    = b_q + {{ptr_size{1'b0}}, rd_acc};
    g_d    = (b_d >> 1) ^ b_d;
    // Gray-to-binary of the synchronised write pointer, MSB downward
    b_wr        = '0;
    b_wr[W-1]   = bus.g_wr_ptr_sync[W-1];
    for (int i = W-2; i >= 0; i--)
      b_wr[i] = b_wr[i+1] ^ bus.g_wr_ptr_sync[i];
    cnt_d    = b_wr - b_d;
    empty_d  = (g_d == bus.g_wr_ptr_sync);
    ae_d     = (cnt_d <= bus.ae_level);
    // set beats clear when both occur in one cycle
    uf_d     = (uf_q & ~bus.clr_err) | (bus.rd_en & empty_q);
    vld_pipe = {vld_q, rd_acc};
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      b_q     <= '0;
      g_q     <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      uf_q    <= 1'b0;
      vld_q   <= '0;
    end else begin
      b_q     <= b_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      uf_q    <= uf_d;
      vld_q   <= vld_pipe[rd_latency-1:0];
    end
  end

  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.rd_count     = cnt_q;
  assign bus.rd_valid     = vld_q[rd_latency-1];
  assign bus.underflow    = uf_q;
  assign bus.b_rd_ptr     = b_q;
  assign bus.rd_addr      = b_q[ptr_size-1:0];
  assign bus.g_rd_ptr     = g_q;
endmodule

// File: tb/tb_read_ptr_ctrl.sv
// Directed bench for read_ptr_ctrl: vector table plus wrap, latency-3 and reset-flush sequences.
module tb_read_ptr_ctrl;
  logic clk = 1'b0;
  logic rst, rst3;
  always #5 clk = ~clk;

  read_ptr_ctrl_if #(.ptr_size(4)) bus  ();
  read_ptr_ctrl_if #(.ptr_size(4)) bus3 ();

  read_ptr_ctrl #(.ptr_size(4), .rd_latency(1)) dut  (.rd_clk(clk), .rst(rst),  .bus(bus));
  read_ptr_ctrl #(.ptr_size(4), .rd_latency(3)) dut3 (.rd_clk(clk), .rst(rst3), .bus(bus3));

  typedef struct {
    logic       rst, rd_en, clr;
    logic [4:0] gw;
    logic       e, ae;
    logic [4:0] cnt;
    logic       v, uf;
    logic [4:0] b;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [4:0] gray(input int n);
    logic [4:0] x;
    x = n[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    bus.rd_en = 1'b0; bus.clr_err = 1'b0; bus.g_wr_ptr_sync = '0; bus.ae_level = 5'd2;
    bus3.rd_en = 1'b0; bus3.clr_err = 1'b0; bus3.g_wr_ptr_sync = '0; bus3.ae_level = 5'd2;

    //              rst rd  clr gw     e  ae cnt   v  uf b
    tbl.push_back('{1, 1, 0, 5'h00, 1, 1, 5'd0,  0, 0, 5'd0});
    tbl.push_back('{1, 1, 0, 5'h00, 1, 1, 5'd0,  0, 0, 5'd0});
    tbl.push_back('{0, 0, 0, 5'h07, 0, 0, 5'd5,  0, 0, 5'd0});
    tbl.push_back('{0, 1, 0, 5'h07, 0, 0, 5'd4,  1, 0, 5'd1});
    tbl.push_back('{0, 1, 0, 5'h07, 0, 0, 5'd3,  1, 0, 5'd2});
    tbl.push_back('{0, 1, 0, 5'h07, 0, 1, 5'd2,  1, 0, 5'd3});
    tbl.push_back('{0, 1, 0, 5'h07, 0, 1, 5'd1,  1, 0, 5'd4});
    tbl.push_back('{0, 1, 0, 5'h07, 1, 1, 5'd0,  1, 0, 5'd5});
    tbl.push_back('{0, 0, 0, 5'h07, 1, 1, 5'd0,  0, 0, 5'd5});
    tbl.push_back('{0, 1, 0, 5'h07, 1, 1, 5'd0,  0, 1, 5'd5});
    tbl.push_back('{0, 0, 0, 5'h07, 1, 1, 5'd0,  0, 1, 5'd5});
    tbl.push_back('{0, 1, 1, 5'h07, 1, 1, 5'd0,  0, 1, 5'd5});
    tbl.push_back('{0, 0, 1, 5'h07, 1, 1, 5'd0,  0, 0, 5'd5});
    tbl.push_back('{0, 0, 0, 5'h05, 0, 1, 5'd1,  0, 0, 5'd5});
    tbl.push_back('{0, 1, 0, 5'h04, 0, 1, 5'd1,  1, 0, 5'd6});
    tbl.push_back('{0, 0, 0, 5'h04, 0, 1, 5'd1,  0, 0, 5'd6});
    tbl.push_back('{1, 0, 0, 5'h18, 1, 1, 5'd0,  0, 0, 5'd0});
    tbl.push_back('{0, 0, 0, 5'h18, 0, 0, 5'd16, 0, 0, 5'd0});
    tbl.push_back('{0, 1, 0, 5'h18, 0, 0, 5'd15, 1, 0, 5'd1});

    foreach (tbl[k]) begin
      rst = tbl[k].rst; bus.rd_en = tbl[k].rd_en; bus.clr_err = tbl[k].clr;
      bus.g_wr_ptr_sync = tbl[k].gw;
      tick();
      chk($sformatf("v%0d empty", k),        bus.empty,        tbl[k].e);
      chk($sformatf("v%0d almost_empty", k), bus.almost_empty, tbl[k].ae);
      chk($sformatf("v%0d rd_count", k),     bus.rd_count,     tbl[k].cnt);
      chk($sformatf("v%0d rd_valid", k),     bus.rd_valid,     tbl[k].v);
      chk($sformatf("v%0d underflow", k),    bus.underflow,    tbl[k].uf);
      chk($sformatf("v%0d b_rd_ptr", k),     bus.b_rd_ptr,     tbl[k].b);
      chk($sformatf("v%0d g_rd_ptr", k),     bus.g_rd_ptr,     gray(int'(tbl[k].b)));
      chk($sformatf("v%0d rd_addr", k),      bus.rd_addr,      tbl[k].b[3:0]);
    end

    // Wrap: one write then one read, 40 times
    rst = 1'b1; bus.rd_en = 1'b0; bus.clr_err = 1'b0; bus.g_wr_ptr_sync = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.g_wr_ptr_sync = gray(i + 1);
      bus.rd_en = 1'b0;
      tick();
      chk($sformatf("wrap%0d cnt_fill", i), bus.rd_count, 1);
      chk($sformatf("wrap%0d empty_fill", i), bus.empty, 0);
      bus.rd_en = 1'b1;
      tick();
      chk($sformatf("wrap%0d b", i),    bus.b_rd_ptr, (i + 1) % 32);
      chk($sformatf("wrap%0d g", i),    bus.g_rd_ptr, gray(i + 1));
      chk($sformatf("wrap%0d addr", i), bus.rd_addr,  (i + 1) % 16);
      chk($sformatf("wrap%0d cnt", i),  bus.rd_count, 0);
      chk($sformatf("wrap%0d empty", i), bus.empty,   1);
      if (i == 31) chk("wrap g_zero", bus.g_rd_ptr, 0);
    end
    bus.rd_en = 1'b0;

    // Latency-3 instance: simultaneous read/write, then reset flushing the valid pipe
    tick();
    rst3 = 1'b0; bus3.g_wr_ptr_sync = gray(1);
    tick();
    chk("l3 cnt_init", bus3.rd_count, 1);
    bus3.rd_en = 1'b1; bus3.g_wr_ptr_sync = gray(2);
    tick();
    chk("l3 cnt_net",   bus3.rd_count, 1);
    chk("l3 empty_net", bus3.empty, 0);
    chk("l3 valid_e0",  bus3.rd_valid, 0);
    bus3.rd_en = 1'b0;
    tick(); chk("l3 valid_e1", bus3.rd_valid, 0);
    tick(); chk("l3 valid_e2", bus3.rd_valid, 1);
    tick(); chk("l3 valid_e3", bus3.rd_valid, 0);
    bus3.rd_en = 1'b1; bus3.g_wr_ptr_sync = gray(3);
    tick();
    chk("l3 b_second", bus3.b_rd_ptr, 2);
    bus3.rd_en = 1'b0; rst3 = 1'b1;
    tick(); chk("l3 flush_a", bus3.rd_valid, 0);
    rst3 = 1'b0;
    tick(); chk("l3 flush_b", bus3.rd_valid, 0);
    tick(); chk("l3 flush_c", bus3.rd_valid, 0);
    chk("l3 b_reset", bus3.b_rd_ptr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
